dmem_xlat_stage: RTL

//  Data-side address translation stage between the LSU issue port and the D-cache request port.

---
 rtl/cpu_defs_pkg.sv | 41 ++++
 rtl/dmem_xlat_stage_skid.sv | 75 +++++++
 rtl/dmem_xlat_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the data-side translation path: MMU result,
// exception codes and the request/response records of dmem_xlat_stage.
package cpu_defs;

    localparam int DMEM_TAG_WIDTH = 6;

    localparam logic [4:0] EXCCODE_MOD  = 5'd1;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;

    typedef struct packed {
        logic [31:0] phy_addr;
        logic        uncached;
        logic        dirty;
        logic        miss;
        logic        invalid;
        logic        illegal;
    } mmu_result_t;

    typedef struct packed {
        logic [31:0]               vaddr;
        logic                      store;
        logic [1:0]                size;
        logic [DMEM_TAG_WIDTH-1:0] tag;
    } dmem_xlat_req_t;

    typedef struct packed {
        logic [31:0]               paddr;
        logic                      uncached;
        logic                      store;
        logic [1:0]                size;
        logic [DMEM_TAG_WIDTH-1:0] tag;
        logic                      exc_valid;
        logic [4:0]                exc_code;
        logic                      tlb_refill;
        logic [31:0]               badvaddr;
    } dmem_xlat_resp_t;

endpackage

// File: rtl/dmem_xlat_stage_skid.sv
// Two-entry valid/ready skid buffer. in_ready_o is registered (~skid full),
// so it never depends combinationally on out_ready_i. Handshake: a beat moves
// on a side only in a cycle where both valid and ready are high on that side.
module pipe_skid_buf #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    T     main_q, main_d;
    T     skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic push;
    logic pop;

    assign push = in_valid_i & ~skid_vld_q;
    assign pop  = main_vld_q & out_ready_i;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (pop) begin
            // Skid full implies no push this cycle, so the skid entry simply advances.
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (push) begin
                main_d = in_data_i;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (push) begin
            if (main_vld_q) begin
                skid_d     = in_data_i;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = in_data_i;
                main_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign in_ready_o  = ~skid_vld_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/dmem_xlat_stage.sv
// Data-side address translation stage: feeds the MMU, classifies exceptions and
// snapshots the translated request into a 2-entry skid buffer toward the D-cache.
module dmem_xlat_stage
    import cpu_defs::*;
#(
    parameter int TAG_WIDTH = DMEM_TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_vaddr,
    input  logic                 req_store,
    input  logic [1:0]           req_size,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic [31:0]          mmu_vaddr,
    input  mmu_result_t          mmu_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_paddr,
    output logic                 out_uncached,
    output logic                 out_store,
    output logic [1:0]           out_size,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_exc_valid,
    output logic [4:0]           out_exc_code,
    output logic                 out_tlb_refill,
    output logic [31:0]          out_badvaddr
);

    // Priority: misaligned/illegal > refill > invalid > Mod. Size 3 behaves as word.
    function automatic dmem_xlat_resp_t xlat_classify(dmem_xlat_req_t req, mmu_result_t mmu);
        dmem_xlat_resp_t r;
        logic            misaligned;
        r            = '0;
        r.paddr      = mmu.phy_addr;
        r.uncached   = mmu.uncached;
        r.store      = req.store;
        r.size       = req.size;
        r.tag        = req.tag;
        r.badvaddr   = req.vaddr;
        misaligned   = ((req.size == 2'd1) && req.vaddr[0]) ||
                       (req.size[1] && (req.vaddr[1:0] != 2'b00));
        if (misaligned || mmu.illegal) begin
            r.exc_valid = 1'b1;
            r.exc_code  = req.store ? EXCCODE_ADES : EXCCODE_ADEL;
        end else if (mmu.miss) begin
            r.exc_valid  = 1'b1;
            r.exc_code   = req.store ? EXCCODE_TLBS : EXCCODE_TLBL;
            r.tlb_refill = 1'b1;
        end else if (mmu.invalid) begin
            r.exc_valid = 1'b1;
            r.exc_code  = req.store ? EXCCODE_TLBS : EXCCODE_TLBL;
        end else if (req.store && !mmu.dirty) begin
            r.exc_valid = 1'b1;
            r.exc_code  = EXCCODE_MOD;
        end
        return r;
    endfunction

    dmem_xlat_req_t  req;
    dmem_xlat_resp_t resp_in;
    dmem_xlat_resp_t resp_out;

    assign mmu_vaddr = req_vaddr;
    assign req.vaddr = req_vaddr;
    assign req.store = req_store;
    assign req.size  = req_size;
    assign req.tag   = req_tag;
    assign resp_in   = xlat_classify(req, mmu_result);

    pipe_skid_buf #(
        .T (dmem_xlat_resp_t)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (req_valid & ~flush),
        .in_ready_o  (req_ready),
        .in_data_i   (resp_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (resp_out)
    );

    assign out_paddr      = resp_out.paddr;
    assign out_uncached   = resp_out.uncached;
    assign out_store      = resp_out.store;
    assign out_size       = resp_out.size;
    assign out_tag        = resp_out.tag;
    assign out_exc_valid  = resp_out.exc_valid;
    assign out_exc_code   = resp_out.exc_code;
    assign out_tlb_refill = resp_out.tlb_refill;
    assign out_badvaddr   = resp_out.badvaddr;

endmodule
